// File: rtl/rega_pkg.sv
// Shared types and constants for the watering-cycle sequencer.
// Optional build macro: REGA_SENSOR_EN (soil-moisture input, see rega_timer_ctrl).
package rega_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_t;

    // One BCD decade
    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // True when the digit is a legal BCD value
    function automatic logic is_bcd(input bcd_t d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/rega_timer_ctrl_bcd_down_digit.sv
// One BCD decade down-counter: synchronous clear, load, enabled decrement
// with 0 -> 9 wrap. borrow_out is high while the digit sits at 0, i.e. the
// next enabled decrement will wrap and must borrow from the next decade.
module bcd_down_digit
    import rega_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic       clr,
    input  logic       load,
    input  logic       en,
    input  logic [3:0] load_val,
    output logic [3:0] q,
    output logic       borrow_out
);

    // Digit register: clear has priority over load, load over decrement
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (Rst || clr) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= (q == '0) ? BCD_MAX : q - 4'd1;
        end
    end

    assign borrow_out = (q == '0);

endmodule

// File: rtl/rega_timer_ctrl.sv
// Watering-cycle sequencer: loads a two-digit BCD duration, counts it down
// one step every TICK_DIV clocks while the valve is open, supports
// pause/resume/abort and pulses Done on completion.
// Optional build macro: REGA_SENSOR_EN adds the Umido (soil wet) input,
// which ends an active cycle immediately and blocks new starts.
// TICK_DIV must be >= 2 and fit in PRE_W bits.
module rega_timer_ctrl
    import rega_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int PRE_W    = 8
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Start,
    input  logic       Stop,
    input  logic [3:0] Preset_Dez,
    input  logic [3:0] Preset_Uni,
`ifdef REGA_SENSOR_EN
    input  logic       Umido,
`endif
    output logic [3:0] Q_dez,
    output logic [3:0] Q_uni,
    output logic       Valve,
    output logic       Busy,
    output logic       Done
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    state_t           state;
    logic [PRE_W-1:0] pre;

    logic wet;
    logic preset_zero;
    logic start_req;
    logic load_go;
    logic step_go;
    logic last_step;
    logic force_done;
    logic abort_go;
    logic clr_go;
    logic uni_borrow;
    logic dez_zero;

`ifdef REGA_SENSOR_EN
    assign wet = Umido;
`else
    assign wet = 1'b0;
`endif

    // Decode the cycle's control decisions shared by the FSM and the digits
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch can be inferred.
        preset_zero = 1'b0;
        start_req   = 1'b0;
        load_go     = 1'b0;
        step_go     = 1'b0;
        last_step   = 1'b0;
        force_done  = 1'b0;
        abort_go    = 1'b0;

        preset_zero = (Preset_Dez == '0) && (Preset_Uni == '0);
        // Stop wins over Start; an out-of-range digit or wet soil blocks Start
        start_req   = (state == ST_IDLE) && Start && !Stop && !wet
                      && is_bcd(Preset_Dez) && is_bcd(Preset_Uni);
        load_go     = start_req && !preset_zero;
        force_done  = ((state == ST_RUN) || (state == ST_PAUSE)) && wet;
        abort_go    = (state == ST_PAUSE) && Stop && !wet;
        // Every cycle spent with the valve open advances the timer, including
        // the one that ends at a Stop edge, so pauses never change open time.
        step_go     = (state == ST_RUN) && !wet && (pre == PRE_LAST);
        last_step   = step_go && dez_zero && (Q_uni == 4'd1);
    end

    assign clr_go = force_done || abort_go;

    bcd_down_digit u_uni (
        .Clk        (Clk),
        .Rst        (Rst),
        .clr        (clr_go),
        .load       (load_go),
        .en         (step_go),
        .load_val   (Preset_Uni),
        .q          (Q_uni),
        .borrow_out (uni_borrow)
    );

    bcd_down_digit u_dez (
        .Clk        (Clk),
        .Rst        (Rst),
        .clr        (clr_go),
        .load       (load_go),
        .en         (step_go && uni_borrow),
        .load_val   (Preset_Dez),
        .q          (Q_dez),
        .borrow_out (dez_zero)
    );

    // Sequencer FSM with prescaler and registered Valve/Busy/Done
    always_ff @(posedge Clk) begin
        // NOTE: reset is sampled on the clock edge only; Rst is a plain synchronous input.
        if (Rst) begin
            state <= ST_IDLE;
            pre   <= '0;
            Valve <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        if (preset_zero) begin
                            state <= ST_DONE;
                            Done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            pre   <= '0;
                            Valve <= 1'b1;
                            Busy  <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    if (force_done) begin
                        state <= ST_DONE;
                        Valve <= 1'b0;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end else begin
                        pre <= (pre == PRE_LAST) ? '0 : pre + PRE_W'(1);
                        if (last_step) begin
                            state <= ST_DONE;
                            Valve <= 1'b0;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                        end else if (Stop) begin
                            state <= ST_PAUSE;
                            Valve <= 1'b0;
                        end
                    end
                end

                ST_PAUSE: begin
                    if (force_done) begin
                        state <= ST_DONE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end else if (Stop) begin
                        state <= ST_IDLE;
                        Busy  <= 1'b0;
                    end else if (Start) begin
                        state <= ST_RUN;
                        Valve <= 1'b1;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                    Valve <= 1'b0;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rega_timer_ctrl.sv
// Self-checking bench for rega_timer_ctrl (TICK_DIV = 4): a vector table,
// hand-written multi-cycle sequences, and randomized stimulus compared
// against a cycle-count reference model.
module tb_rega_timer_ctrl;

    localparam int TICK_DIV = 4;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Start;
    logic       Stop;
    logic [3:0] Preset_Dez;
    logic [3:0] Preset_Uni;
    logic       Umido = 1'b0;
    logic [3:0] Q_dez;
    logic [3:0] Q_uni;
    logic       Valve;
    logic       Busy;
    logic       Done;

    int n_vec = 0;
    int n_bad = 0;

    rega_timer_ctrl #(.TICK_DIV(TICK_DIV), .PRE_W(8)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Start      (Start),
        .Stop       (Stop),
        .Preset_Dez (Preset_Dez),
        .Preset_Uni (Preset_Uni),
`ifdef REGA_SENSOR_EN
        .Umido      (Umido),
`endif
        .Q_dez      (Q_dez),
        .Q_uni      (Q_uni),
        .Valve      (Valve),
        .Busy       (Busy),
        .Done       (Done)
    );

    initial forever #5 Clk = ~Clk;

    // {Q_dez, Q_uni, Valve, Busy, Done}
    function automatic logic [10:0] outs();
        return {Q_dez, Q_uni, Valve, Busy, Done};
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got count=%h valve/busy/done=%b, want count=%h valve/busy/done=%b",
                     name, act[10:3], act[2:0], exp[10:3], exp[2:0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One clock edge, then settle away from the edge before sampling
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    localparam int M_OFF  = 0;
    localparam int M_OPEN = 1;
    localparam int M_HELD = 2;
    localparam int M_FIN  = 3;

    int m_mode  = M_OFF;
    int m_left  = 0;   // remaining steps, plain decimal
    int m_phase = 0;   // cycles of open valve since the last step

    task automatic model_edge(input logic rst, start, stop, input logic [3:0] pd, pu, input logic wet);
        int v;
        if (rst) begin
            m_mode = M_OFF; m_left = 0; m_phase = 0;
            return;
        end
        case (m_mode)
            M_OFF: begin
                if (start && !stop && !wet && pd <= 9 && pu <= 9) begin
                    v = int'(pd) * 10 + int'(pu);
                    if (v == 0) m_mode = M_FIN;
                    else begin m_left = v; m_phase = 0; m_mode = M_OPEN; end
                end
            end
            M_OPEN: begin
                if (wet) begin
                    m_left = 0; m_mode = M_FIN;
                end else begin
                    m_phase++;
                    if (m_phase == TICK_DIV) begin m_phase = 0; m_left--; end
                    if (m_left == 0) m_mode = M_FIN;
                    else if (stop) m_mode = M_HELD;
                end
            end
            M_HELD: begin
                if (wet) begin m_left = 0; m_mode = M_FIN; end
                else if (stop) begin m_left = 0; m_mode = M_OFF; end
                else if (start) m_mode = M_OPEN;
            end
            default: m_mode = M_OFF;
        endcase
    endtask

    function automatic logic [10:0] model_outs();
        return {4'(m_left / 10), 4'(m_left % 10), m_mode == M_OPEN,
                (m_mode == M_OPEN) || (m_mode == M_HELD), m_mode == M_FIN};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic       start;
        logic       stop;
        logic [3:0] pd;
        logic [3:0] pu;
        logic [10:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic s, st, input logic [3:0] d, u,
                                input logic [7:0] cnt, input logic [2:0] fl);
        vec_t r;
        r.start = s; r.stop = st; r.pd = d; r.pu = u; r.exp = {cnt, fl};
        return r;
    endfunction

    vec_t tbl[23];

    initial begin
        int k;
        int open;

        tbl[0]  = mk(1, 0, 4'h0, 4'h0, 8'h00, 3'b001); // preset 00 -> immediate Done
        tbl[1]  = mk(0, 0, 4'h0, 4'h0, 8'h00, 3'b000);
        tbl[2]  = mk(1, 0, 4'h0, 4'hA, 8'h00, 3'b000); // invalid units digit ignored
        tbl[3]  = mk(1, 1, 4'h0, 4'h1, 8'h00, 3'b000); // Start+Stop in IDLE
        tbl[4]  = mk(1, 0, 4'h0, 4'h2, 8'h02, 3'b110); // load 02
        tbl[5]  = mk(0, 0, 4'h9, 4'h9, 8'h02, 3'b110); // preset change ignored
        tbl[6]  = mk(0, 0, 4'h9, 4'h9, 8'h02, 3'b110);
        tbl[7]  = mk(0, 0, 4'h9, 4'h9, 8'h02, 3'b110);
        tbl[8]  = mk(0, 0, 4'h9, 4'h9, 8'h01, 3'b110); // first step
        tbl[9]  = mk(0, 1, 4'h9, 4'h9, 8'h01, 3'b010); // pause
        tbl[10] = mk(1, 0, 4'h9, 4'h9, 8'h01, 3'b110); // resume, no reload
        tbl[11] = mk(0, 0, 4'h9, 4'h9, 8'h01, 3'b110);
        tbl[12] = mk(0, 0, 4'h9, 4'h9, 8'h01, 3'b110);
        tbl[13] = mk(0, 0, 4'h9, 4'h9, 8'h00, 3'b001); // last step -> Done
        tbl[14] = mk(0, 0, 4'h9, 4'h9, 8'h00, 3'b000);
        tbl[15] = mk(1, 0, 4'h1, 4'h0, 8'h10, 3'b110); // load 10
        tbl[16] = mk(0, 1, 4'h1, 4'h0, 8'h10, 3'b010); // pause
        tbl[17] = mk(0, 1, 4'h1, 4'h0, 8'h00, 3'b000); // abort, no Done
        tbl[18] = mk(0, 0, 4'h1, 4'h0, 8'h00, 3'b000);
        tbl[19] = mk(1, 0, 4'h0, 4'h3, 8'h03, 3'b110); // load 03
        tbl[20] = mk(1, 0, 4'h0, 4'h9, 8'h03, 3'b110); // Start ignored in RUN
        tbl[21] = mk(1, 1, 4'h0, 4'h9, 8'h03, 3'b010); // Start+Stop in RUN -> pause
        tbl[22] = mk(0, 1, 4'h0, 4'h9, 8'h00, 3'b000); // abort

        // Reset
        Rst = 1'b1; Start = 1'b0; Stop = 1'b0; Preset_Dez = '0; Preset_Uni = '0;
        repeat (2) cyc();
        check("reset", outs(), 11'b0);
        Rst = 1'b0;

        // Table
        for (int i = 0; i < 23; i++) begin
            Start = tbl[i].start; Stop = tbl[i].stop;
            Preset_Dez = tbl[i].pd; Preset_Uni = tbl[i].pu;
            cyc();
            check($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end
        Start = 1'b0; Stop = 1'b0;

        // Normal run, preset 12: 48 open cycles, borrow on the third step
        Preset_Dez = 4'd1; Preset_Uni = 4'd2; Start = 1'b1;
        cyc();
        Start = 1'b0;
        check("run12_load", outs(), {8'h12, 3'b110});
        open = Valve ? 1 : 0;
        k = 0;
        while (!Done && k < 200) begin
            cyc();
            k++;
            if (k == 4)  check_int("run12_step1", {Q_dez, Q_uni}, 'h11);
            if (k == 8)  check_int("run12_step2", {Q_dez, Q_uni}, 'h10);
            if (k == 12) check_int("run12_step3", {Q_dez, Q_uni}, 'h09);
            if (Valve) open++;
        end
        check_int("run12_done_cycle", k, 48);
        check_int("run12_open", open, 48);
        check("run12_done", outs(), {8'h00, 3'b001});
        cyc();
        check("run12_idle", outs(), 11'b0);

        // Pause at 07 for 10 cycles, resume; total open time unchanged
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        open = Valve ? 1 : 0;
        for (int j = 1; j <= 22; j++) begin
            cyc();
            if (j == 20) check_int("pause_at07", {Q_dez, Q_uni}, 'h07);
            if (Valve) open++;
        end
        Stop = 1'b1;
        cyc();
        Stop = 1'b0;
        check("pause_enter", outs(), {8'h07, 3'b010});
        for (int j = 0; j < 10; j++) begin
            cyc();
            check("pause_hold", outs(), {8'h07, 3'b010});
        end
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        check("pause_resume", outs(), {8'h07, 3'b110});
        if (Valve) open++;
        k = 0;
        while (!Done && k < 200) begin
            cyc();
            k++;
            if (Valve) open++;
        end
        check_int("pause_tail", k, 25);
        check_int("pause_open_total", open, 48);
        cyc();

        // Reset in the middle of a run at count 05
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        repeat (28) cyc();
        check("rst_at05_pre", outs(), {8'h05, 3'b110});
        Rst = 1'b1;
        cyc();
        check("rst_at05", outs(), 11'b0);
        Rst = 1'b0;
        cyc();
        check("rst_at05_idle", outs(), 11'b0);

`ifdef REGA_SENSOR_EN
        // Wet soil ends a run at 30 and blocks a new start
        Preset_Dez = 4'd3; Preset_Uni = 4'd1; Start = 1'b1;
        cyc();
        Start = 1'b0;
        repeat (4) cyc();
        check("wet_at30_pre", outs(), {8'h30, 3'b110});
        Umido = 1'b1;
        cyc();
        check("wet_at30", outs(), {8'h00, 3'b001});
        cyc();
        Start = 1'b1;
        cyc();
        check("wet_blocks_start", outs(), 11'b0);
        Start = 1'b0; Umido = 1'b0;
`endif

        // Randomized stimulus against the reference model
        Rst = 1'b1;
        cyc();
        model_edge(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        check("rand_reset", outs(), model_outs());
        for (int n = 0; n < 3000; n++) begin
            int r;
            Rst   = ($urandom_range(0, 299) == 0);
            Start = ($urandom_range(0, 3) == 0);
            Stop  = ($urandom_range(0, 11) == 0);
            r = $urandom_range(0, 9);
            if (r == 0) begin
                Preset_Dez = 4'd0; Preset_Uni = 4'd0;
            end else if (r == 1) begin
                Preset_Dez = 4'($urandom_range(10, 15)); Preset_Uni = 4'($urandom_range(0, 9));
            end else if (r == 2) begin
                Preset_Dez = 4'($urandom_range(0, 1)); Preset_Uni = 4'($urandom_range(10, 15));
            end else begin
                Preset_Dez = 4'($urandom_range(0, 1)); Preset_Uni = 4'($urandom_range(0, 9));
            end
`ifdef REGA_SENSOR_EN
            Umido = ($urandom_range(0, 39) == 0);
`endif
            cyc();
            model_edge(Rst, Start, Stop, Preset_Dez, Preset_Uni, Umido);
            check($sformatf("rand%0d", n), outs(), model_outs());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
